// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage feeding the decode stage.
//   Generates sequential PCs, issues one instruction-memory read per cycle
//   while queue credits remain, and buffers the returned words with their PCs
//   in a small FIFO. Returned words are predecoded so that direct B/BL
//   redirect the fetch PC and HLT stops fetching. A back-end redirect flushes
//   everything and restarts fetch at the supplied target.
// Ports:
//   in_clk, in_rst             clock (posedge), asynchronous active-high reset
//   out_imem_req/out_imem_addr read request and address (current PC)
//   in_imem_data               instruction word, valid one cycle after a request
//   in_stall                   decode cannot accept; hold the queue head
//   in_redirect/in_redirect_pc back-end redirect and its target
//   out_insnbits/out_pc        instruction and its PC handed to decode
//   out_done                   one-cycle pulse per delivered instruction
//   out_halted                 fetch has stopped after HLT
module fetch_unit #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic        in_clk,
  input  logic        in_rst,
  output logic        out_imem_req,
  output logic [63:0] out_imem_addr,
  input  logic [31:0] in_imem_data,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [63:0] in_redirect_pc,
  output logic [31:0] out_insnbits,
  output logic [63:0] out_pc,
  output logic        out_done,
  output logic        out_halted
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e           state_q;
  logic [63:0]      pc_q;
  logic             inflight_q;
  logic [63:0]      inflight_pc_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      insn_q     [QUEUE_DEPTH];
  logic [63:0]      insn_pc_q  [QUEUE_DEPTH];

  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic             is_branch;
  logic             is_hlt;
  logic [63:0]      br_target;

  // A request is only made when a queue slot is guaranteed for its response,
  // counting the one response that may already be in flight.
  assign credit_ok = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q})
                     < (CNT_W + 1)'(QUEUE_DEPTH);
  assign issue     = (state_q == ST_RUN) & ~in_rst & ~in_redirect & credit_ok;

  assign out_imem_req  = issue;
  assign out_imem_addr = pc_q;

  // The in-flight flag is cleared whenever a response must be squashed, so a
  // valid response is simply "something in flight and no redirect now".
  assign push = inflight_q & ~in_redirect;
  assign pop  = (count_q != {CNT_W{1'b0}}) & ~in_stall & ~in_redirect;

  assign is_branch = (in_imem_data[31:26] == 6'b000101) |
                     (in_imem_data[31:26] == 6'b100101);
  assign is_hlt    = (in_imem_data[31:21] == 11'b11010100010) &
                     (in_imem_data[4:0] == 5'b00000);
  // imm26 is a word offset: sign-extend from bit 25 and scale by 4.
  assign br_target = inflight_pc_q +
                     {{36{in_imem_data[25]}}, in_imem_data[25:0], 2'b00};

  // Fetch FSM, PC, in-flight tracking, queue pointers and registered outputs.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 64'h0;
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      out_insnbits  <= 32'h0;
      out_pc        <= 64'h0;
      out_done      <= 1'b0;
      out_halted    <= 1'b0;
    end else if (in_redirect) begin
      state_q    <= ST_RUN;
      pc_q       <= in_redirect_pc;
      inflight_q <= 1'b0;
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      out_done   <= 1'b0;
      out_halted <= 1'b0;
    end else begin
      // Predecode of the arriving word overrides a request made this cycle:
      // that request is on the wrong path, so it is dropped by not marking
      // it in flight.
      if (push && is_branch) begin
        pc_q       <= br_target;
        inflight_q <= 1'b0;
      end else if (push && is_hlt) begin
        state_q    <= ST_HALT;
        out_halted <= 1'b1;
        inflight_q <= 1'b0;
      end else if (issue) begin
        pc_q          <= pc_q + 64'd4;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        out_insnbits <= insn_q[rd_ptr_q];
        out_pc       <= insn_pc_q[rd_ptr_q];
        out_done     <= 1'b1;
      end else begin
        out_done <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge in_clk) begin
    if (push) begin
      insn_q[wr_ptr_q]    <= in_imem_data;
      insn_pc_q[wr_ptr_q] <= inflight_pc_q;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage and producer of the fetch_interface signals the decode stage consumes: insnbits, pc, done.
- Generates sequential PCs, issues instruction-memory reads, and buffers responses in a small instruction queue.
- Statically redirects on direct B/BL, stops at HLT, and flushes on back-end redirects (mispredict/BR/RET resolution).
- Sits between the instruction memory and the decode stage.

Parameters:
- QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2).
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- in_clk  input  1  clock, all state on posedge.
- in_rst  input  1  reset, asynchronous, active-high.
- out_imem_req  output  1  read request this cycle.
- out_imem_addr  output  64  read address (current PC).
- in_imem_data  input  32  instruction word; valid exactly 1 cycle after a request.
- in_stall  input  1  downstream cannot accept; hold queue head.
- in_redirect  input  1  back-end redirect; flush and refetch.
- in_redirect_pc  input  64  redirect target.
- out_insnbits  output  32  instruction to decode.
- out_pc  output  64  PC of out_insnbits.
- out_done  output  1  out_insnbits/out_pc valid this cycle (single-cycle pulse per instruction).
- out_halted  output  1  fetch stopped after HLT.

Behaviour:
- Reset (async): pc=RESET_PC, queue empty, no in-flight, state=RUN. Outputs out_done=0, out_imem_req=0, out_insnbits=0, out_pc=0, out_halted=0.
- States:
  - RUN: fetching.
  - HALT: no requests.
  - HALT -> RUN only on in_redirect. No other transitions out of HALT.
- Request issue (combinational):
  - out_imem_req = (state==RUN) & ~in_redirect & (count + inflight < QUEUE_DEPTH).
  - out_imem_addr = pc.
  - On issue: pc <= pc+4, inflight <= 1, inflight_pc <= pc. At most one request per cycle.
- Response, cycle after issue, if not squashed: push {in_imem_data, inflight_pc}. Predecode the pushed word:
  - B (bits[31:26]=000101) or BL (100101): pc <= inflight_pc + sext(imm26)*4; squash any request issued this same cycle.
  - HLT (bits[31:21]=11010100010, bits[4:0]=0): state <= HALT, out_halted <= 1; squash any request issued this same cycle. The HLT itself is enqueued.
  - Otherwise no PC change.
- Squashed response: discarded, not pushed, no predecode.
- Output (registered):
  - If queue non-empty & ~in_stall & ~in_redirect: pop head; out_insnbits/out_pc <= head; out_done <= 1.
  - Else out_done <= 0; out_insnbits/out_pc hold.
  - Latency: response cycle t pushes at end of t; earliest out_done at t+1 when the queue was empty.
- Simultaneous push and pop in one cycle: count unchanged, FIFO order preserved.
- Full: the credit rule never issues a request without a guaranteed slot, so overflow cannot occur. Fill levels covered: count=QUEUE_DEPTH with inflight=0, and count=QUEUE_DEPTH-1 with inflight=1.
- Empty with ~in_stall: out_done <= 0.
- in_redirect (priority over everything, including stall, predecode and HLT):
  - Queue flushed (count=0, pointers reset).
  - Any in-flight response squashed.
  - pc <= in_redirect_pc; state <= RUN; out_halted <= 0; out_done <= 0.
  - First request at redirect target issued the following cycle.
- in_stall: blocks pops only; fetching continues until credits run out.
- Arithmetic: all PC math is 64-bit modulo 2^64; the B/BL offset is sign-extended from bit 25 before <<2.
- Reset asserted mid-operation: immediate return to reset values; any response arriving later is ignored (inflight cleared).

Test Plan:
- Sequential stream: reset, imem returns NOPs (D503201F), in_stall=0 -> out_done pulses with out_pc 0,4,8,C... one per cycle after 3-cycle startup.
- Stall/full: assert in_stall for 10 cycles -> requests stop once 4 entries buffered, no loss; release -> pcs 0,4,8,C drained in order, then resumes at 10.
- Branch: word at 0x8 = 14000004 (B +16) -> request for 0xC squashed; next delivered pc is 0x18; backward B (17FFFFFF at 0x20) -> next pc 0x1C.
- HLT: word D4400000 at 0x4 -> HLT delivered with out_pc=4, out_halted=1, no further out_imem_req; then redirect to 0x100 -> fetch resumes at 0x100, out_halted=0.
- Redirect during stall with full queue and a response in flight -> queue flushed, response dropped, next out_done has out_pc=in_redirect_pc=0x40.
- Async reset asserted mid-stream between clock edges -> outputs zero immediately; after release, first request address = RESET_PC.
